// File: rtl/dp_sram_pkg.sv
// Shared types and helpers for the true dual-port SRAM macro.
// Holds the read-during-write encodings, FSM states and the byte-lane merge function.
package dp_sram_pkg;

    localparam int RD_READ_FIRST  = 0;
    localparam int RD_WRITE_FIRST = 1;

    // The merge works on a fixed maximum width; callers extend on entry and truncate on exit.
    localparam int MERGE_MAX_W  = 256;
    localparam int MERGE_LANE_W = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_W-1:0] be,
        input int unsigned            lane_bits
    );
        logic [MERGE_MAX_W-1:0] res;
        int unsigned            lane;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            lane = i / lane_bits;
            if (lane < MERGE_MAX_W && be[lane[MERGE_LANE_W-1:0]]) begin
                res[i] = new_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_sram_port.sv
// Per-port read path: selects old or byte-merged word, optionally pipelines it,
// and produces an rvalid pulse aligned with the data. Read data holds between accesses.
module dp_sram_port
    import dp_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_acc,
    input  logic                             i_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    input  logic [DATA_WIDTH-1:0]            i_old,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_rvalid
);

    logic [DATA_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Only a port's own write is merged; a reader always sees the array's current word.
    always_comb begin
        sel = i_old;
        if (i_we && RD_MODE == RD_WRITE_FIRST) begin
            sel = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(i_old), MERGE_MAX_W'(i_wdata),
                                         MERGE_MAX_W'(i_be), BYTE_WIDTH));
        end
    end

    always_comb begin
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        if (OUT_REG != 0) begin
            pipe_valid_d = i_acc;
            if (i_acc) begin
                pipe_data_d = sel;
            end
            rvalid_d = pipe_valid_q;
            if (pipe_valid_q) begin
                rdata_d = pipe_data_q;
            end
        end else begin
            rvalid_d = i_acc;
            if (i_acc) begin
                rdata_d = sel;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;

endmodule

// File: rtl/dp_sram_tdp.sv
// True dual-port synchronous SRAM with byte enables, post-reset clear sweep,
// port-A-priority write arbitration and a registered same-address collision flag.
module dp_sram_tdp
    import dp_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_a_en,
    input  logic                             i_a_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_a_be,
    input  logic [ADDR_WIDTH-1:0]            i_a_addr,
    input  logic [DATA_WIDTH-1:0]            i_a_wdata,
    output logic [DATA_WIDTH-1:0]            o_a_rdata,
    output logic                             o_a_rvalid,
    input  logic                             i_b_en,
    input  logic                             i_b_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_b_be,
    input  logic [ADDR_WIDTH-1:0]            i_b_addr,
    input  logic [DATA_WIDTH-1:0]            i_b_wdata,
    output logic [DATA_WIDTH-1:0]            o_b_rdata,
    output logic                             o_b_rvalid,
    output logic                             o_busy,
    output logic                             o_collision,
    output state_e                           o_state
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  collision_q, collision_d;
    logic                  run;
    logic                  init_we;
    logic                  a_acc, b_acc;
    logic                  same_addr;
    logic [NUM_BYTES-1:0]  a_lane_we, b_lane_we;
    logic [DATA_WIDTH-1:0] a_old, b_old;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
        end
    end

    // The extra counter bit flags that the last address has just been cleared.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_inc;
                if (INIT_CLEAR == 0 || cnt_inc[ADDR_WIDTH]) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        run     = (state_q == ST_RUN);
        o_busy  = (state_q == ST_INIT);
        init_we = (state_q == ST_INIT) && (INIT_CLEAR != 0) && !i_rst;
    end

    assign a_acc     = run && i_a_en;
    assign b_acc     = run && i_b_en;
    assign same_addr = (i_a_addr == i_b_addr);
    assign a_old     = mem_q[i_a_addr];
    assign b_old     = mem_q[i_b_addr];

    // Port A owns any lane both ports write at the same address; B keeps its disjoint lanes.
    always_comb begin
        a_lane_we = '0;
        b_lane_we = '0;
        if (a_acc && i_a_we) begin
            a_lane_we = i_a_be;
        end
        if (b_acc && i_b_we) begin
            b_lane_we = i_b_be & ~(same_addr ? a_lane_we : '0);
        end
        collision_d = a_acc && b_acc && same_addr && (i_a_we || i_b_we);
    end

    always_ff @(posedge i_clk) begin
        if (init_we) begin
            mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (a_lane_we[k]) begin
                    mem_q[i_a_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_a_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (b_lane_we[k]) begin
                    mem_q[i_b_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_b_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    dp_sram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .RD_MODE    (RD_MODE),
        .OUT_REG    (OUT_REG)
    ) u_port_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_acc    (a_acc),
        .i_we     (i_a_we),
        .i_be     (i_a_be),
        .i_wdata  (i_a_wdata),
        .i_old    (a_old),
        .o_rdata  (o_a_rdata),
        .o_rvalid (o_a_rvalid)
    );

    dp_sram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .RD_MODE    (RD_MODE),
        .OUT_REG    (OUT_REG)
    ) u_port_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_acc    (b_acc),
        .i_we     (i_b_we),
        .i_be     (i_b_be),
        .i_wdata  (i_b_wdata),
        .i_old    (b_old),
        .o_rdata  (o_b_rdata),
        .o_rvalid (o_b_rvalid)
    );

    assign o_collision = collision_q;
    assign o_state     = state_q;

endmodule

// File: doc/dp_sram_tdp.md
Name: dp_sram_tdp

Overview:
- True dual-port synchronous SRAM with two independent read/write ports (A, B) on one clock.
- Parametrised width, depth, byte-write granularity, read-during-write mode and optional output register.
- Contents are cleared after reset by a built-in sequential sweep, not by a single-cycle array reset.
- Serves as the register-file/data-memory macro for the MIPS core; single-port uses tie port B off.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- OUT_REG, 0, 1 adds one output pipeline register per port.
- INIT_CLEAR, 1, 1 = zero all words after reset; 0 = skip sweep, contents undefined.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_a_en  in  1  port A access request.
- i_a_we  in  1  port A write (valid with i_a_en).
- i_a_be  in  NUM_BYTES  port A byte-lane write enables.
- i_a_addr  in  ADDR_WIDTH  port A address.
- i_a_wdata  in  DATA_WIDTH  port A write data.
- o_a_rdata  out  DATA_WIDTH  port A read data.
- o_a_rvalid  out  1  one-cycle pulse, o_a_rdata valid.
- i_b_*, o_b_*  same set as port A for port B.
- o_busy  out  1  high during reset and init sweep; requests ignored.
- o_collision  out  1  one-cycle pulse, same-address conflict between ports.

Behaviour:
- Reset (i_rst=1 at edge): o_*_rdata=0, o_*_rvalid=0, o_collision=0, o_busy=1, sweep counter=0, pipeline regs=0.
- States: INIT, RUN. Reset forces INIT.
- INIT (INIT_CLEAR=1): each cycle writes 0 to mem[counter], counter++; after writing DEPTH-1 go RUN. o_busy=1 for exactly DEPTH cycles after reset deassert, 0 from cycle DEPTH+1.
- INIT_CLEAR=0: RUN on first cycle after reset deasserts.
- Reset asserted mid-sweep restarts sweep at address 0.
- All i_a_*/i_b_* ignored while o_busy=1 (no writes, no rvalid).
- RUN write: en&we -> for each lane k with be[k]=1, mem[addr][k] <= wdata[k]; other lanes unchanged. be=0 with we=1 is legal no-op write but still counts as a read for rdata.
- RUN read: en&~we -> rdata registered; latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), rvalid aligned with data.
- Write access with en also returns data and rvalid: RD_MODE=0 old word, RD_MODE=1 byte-merged new word.
- o_*_rdata holds last value when no access; rvalid=0.
- Cross-port, same address, same cycle (both en):
  - both write: per-lane, port A wins on lanes both enable; B's disjoint lanes still written; o_collision=1.
  - one writes, other reads: reader gets old word regardless of RD_MODE; o_collision=1.
  - both read: normal, no collision.
- o_collision registered, asserts one cycle after the conflicting request (not delayed by OUT_REG).
- Address width exact; no wrap logic needed beyond natural ADDR_WIDTH truncation; sweep counter is ADDR_WIDTH+1 bits to detect completion.

Decomposition:
- Shared package dp_sram_pkg: RD_MODE encodings (RD_READ_FIRST=0, RD_WRITE_FIRST=1), state encoding (ST_INIT, ST_RUN), function for byte-merge of old/new word.
- One sub-module natural: dp_sram_port (per-port byte-merge, read-data select, optional output register, rvalid pipeline), instantiated twice; array, init sweep, arbitration and collision logic stay in top.

Test Plan:
- Reset then idle, DEPTH=256: o_busy high exactly 256 cycles after i_rst falls; then read A addr 0x00 and 0xFF -> rdata 0x00000000, rvalid 1 cycle later.
- A writes 0xDEADBEEF to 0x10 be=4'b1111, then B reads 0x10 -> o_b_rdata=0xDEADBEEF with latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- Word 0x11223344 at 0x20; A writes 0xAABBCCDD be=4'b0101 -> subsequent read 0x11BB33DD.
- RD_MODE=0 vs 1: A writes 0x55555555 to 0x30 (old 0x0); A rdata 0x00000000 vs 0x55555555; simultaneous B read 0x30 -> 0x00000000 in both modes, o_collision=1.
- Both write 0x40 same cycle: A 0x000000AA be=0001, B 0xBB0000CC be=1001 -> word 0xBB0000AA, o_collision pulse 1 cycle.
- Assert i_rst at sweep address 100, release -> o_busy high 256 more cycles, addr 0 cleared, requests during busy produce no rvalid and no writes.
